// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Purpose:
//   Watches a multiplexed, active-low 3-digit 7-segment display bus and
//   recovers the BCD digit shown on each position. A digit is captured only
//   after the bus ({an_n, seg_n}) has held the same value with exactly one
//   anode active for STABLE_CYCLES consecutive samples.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   seg_n  in   7  segments, active-low, [6:0] = A,B,C,D,E,F,G
//   an_n   in   3  digit enables, active-low; [0]->d1, [1]->d2, [2]->d3
//   clear  in   1  synchronous clear of digits / valid / seen mask
//   d1     out  4  recovered digit 1
//   d2     out  4  recovered digit 2
//   d3     out  4  recovered digit 3
//   valid  out  1  every digit captured at least once since reset/clear
//   upd    out  1  one-cycle pulse: a capture set a digit new or changed it
//   err    out  1  one-cycle pulse: captured pattern is neither 0-9 nor blank
//
// Configuration:
//   SEG7DEC_SYNC_EN  when defined, seg_n/an_n pass through a 2-flop
//                    synchronizer before sampling (adds 2 cycles latency).
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter  int STABLE_CYCLES = 4,
  localparam int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_n,
  input  logic [2:0] an_n,
  input  logic       clear,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       valid,
  output logic       upd,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_CAPTURE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(STABLE_CYCLES);

  state_t           state, state_next;
  logic [9:0]       din;
  logic [9:0]       smp;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       seen;
  logic             changed;
  logic             capture;
  logic [2:0]       cap_an;
  logic [6:0]       cap_seg;
  logic [4:0]       dec;
  logic             blank;

  // Returns {recognised, value}; recognised is 0 for anything but 0-9.
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'b0000001: decode = 5'b1_0000;
      7'b1001111: decode = 5'b1_0001;
      7'b0010010: decode = 5'b1_0010;
      7'b0000110: decode = 5'b1_0011;
      7'b1001100: decode = 5'b1_0100;
      7'b0100100: decode = 5'b1_0101;
      7'b0100000: decode = 5'b1_0110;
      7'b0001111: decode = 5'b1_0111;
      7'b0000000: decode = 5'b1_1000;
      7'b0000100: decode = 5'b1_1001;
      default:    decode = 5'b0_0000;
    endcase
  endfunction

  function automatic logic one_low(input logic [2:0] a);
    one_low = (a == 3'b110) || (a == 3'b101) || (a == 3'b011);
  endfunction

`ifdef SEG7DEC_SYNC_EN
  logic [9:0] sync1, sync2;

  // Pins are asynchronous in this build: two flops before the sample register.
  // Reset to the idle-bus value so nothing looks active coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= {an_n, seg_n};
      sync2 <= sync1;
    end
  end

  assign din = sync2;
`else
  assign din = {an_n, seg_n};
`endif

  assign changed = (din != smp);
  assign capture = (state == TRACK) && (cnt == CNT_CAPTURE);
  assign cap_an  = smp[9:7];
  assign cap_seg = smp[6:0];
  assign dec     = decode(cap_seg);
  assign blank   = (cap_seg == 7'b1111111);
  assign valid   = &seen;

  // Sample register plus stability counter. The counter tells how many edges
  // the current sample has been repeated; it saturates so HOLD never wraps it
  // back onto the capture value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp <= '1;
      cnt <= '0;
    end else begin
      smp <= din;
      if (clear || changed) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A capture in TRACK happens on the same edge that moves
  // to HOLD; a simultaneous bus change still lets that capture complete since
  // the stable value already sits in smp.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (one_low(din[9:7])) state_next = TRACK;
      end
      TRACK: begin
        if (changed)                 state_next = one_low(din[9:7]) ? TRACK : IDLE;
        else if (cnt == CNT_CAPTURE) state_next = HOLD;
      end
      HOLD: begin
        if (changed) state_next = one_low(din[9:7]) ? TRACK : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (clear) state_next = IDLE;
  end

  // Digit capture. Blank patterns are dropped silently, unknown patterns
  // only raise err, and clear overrides a capture on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1   <= '0;
      d2   <= '0;
      d3   <= '0;
      seen <= '0;
      upd  <= 1'b0;
      err  <= 1'b0;
    end else if (clear) begin
      d1   <= '0;
      d2   <= '0;
      d3   <= '0;
      seen <= '0;
      upd  <= 1'b0;
      err  <= 1'b0;
    end else begin
      upd <= 1'b0;
      err <= 1'b0;
      if (capture) begin
        if (dec[4]) begin
          case (cap_an)
            3'b110: begin
              d1      <= dec[3:0];
              seen[0] <= 1'b1;
              upd     <= !seen[0] || (d1 != dec[3:0]);
            end
            3'b101: begin
              d2      <= dec[3:0];
              seen[1] <= 1'b1;
              upd     <= !seen[1] || (d2 != dec[3:0]);
            end
            3'b011: begin
              d3      <= dec[3:0];
              seen[2] <= 1'b1;
              upd     <= !seen[2] || (d3 != dec[3:0]);
            end
            default: ;
          endcase
        end else if (!blank) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Purpose:
//   Directed bench for seg7_scan_decoder. Each stimulus step that should
//   produce a capture pushes its expected digits/flags, tagged with the cycle
//   they must appear on, into a scoreboard queue; a negedge monitor pops and
//   compares them, and on every other cycle insists upd and err stay low.
//
// Ports: none (top-level bench).
//
// Configuration:
//   SEG7DEC_SYNC_EN  when defined, expected capture latency becomes 6 cycles.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

`ifdef SEG7DEC_SYNC_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] d1;
    logic [3:0] d2;
    logic [3:0] d3;
    logic       v;
    logic       u;
    logic       e;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_n;
  logic [2:0] an_n;
  logic       clear;
  logic [3:0] d1, d2, d3;
  logic       valid, upd, err;

  int   cyc;
  int   nChecks;
  int   nFail;
  exp_t sb[$];
  exp_t cur;

  seg7_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seg_n (seg_n),
    .an_n  (an_n),
    .clear (clear),
    .d1    (d1),
    .d2    (d2),
    .d3    (d3),
    .valid (valid),
    .upd   (upd),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkValue(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic checkOutput(input logic [3:0] e1, input logic [3:0] e2,
                             input logic [3:0] e3, input logic ev);
    checkValue("d1", d1, e1);
    checkValue("d2", d2, e2);
    checkValue("d3", d3, e3);
    checkValue("valid", {3'b000, valid}, {3'b000, ev});
  endtask

  // Drives one bus pattern for 'hold' cycles starting at a negedge. When a
  // capture is expected it lands LAT cycles after the first sampling edge.
  task automatic applyStimulus(input logic [2:0] an, input logic [6:0] seg, input int hold,
                               input bit capt, input logic [3:0] e1, input logic [3:0] e2,
                               input logic [3:0] e3, input logic ev, input logic eu,
                               input logic ee);
    exp_t x;
    an_n  = an;
    seg_n = seg;
    if (capt) begin
      x.cyc = cyc + 1 + LAT;
      x.d1 = e1; x.d2 = e2; x.d3 = e3;
      x.v = ev; x.u = eu; x.e = ee;
      sb.push_back(x);
    end
    repeat (hold) @(negedge clk);
  endtask

  // Scoreboard monitor: scheduled entries check everything, all other
  // cycles check that no stray pulse appears.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      cur = sb.pop_front();
      checkValue("sb_d1", d1, cur.d1);
      checkValue("sb_d2", d2, cur.d2);
      checkValue("sb_d3", d3, cur.d3);
      checkValue("sb_valid", {3'b000, valid}, {3'b000, cur.v});
      checkValue("sb_upd", {3'b000, upd}, {3'b000, cur.u});
      checkValue("sb_err", {3'b000, err}, {3'b000, cur.e});
    end else begin
      checkValue("idle_upd", {3'b000, upd}, 4'h0);
      checkValue("idle_err", {3'b000, err}, 4'h0);
    end
  end

  initial begin
    nChecks = 0;
    nFail   = 0;
    cyc     = 0;
    // Reset with arbitrary bus values.
    rst_n = 1'b0;
    clear = 1'b0;
    an_n  = 3'($urandom);
    seg_n = 7'($urandom);
    #3;
    checkOutput(4'd0, 4'd0, 4'd0, 1'b0);
    checkValue("rst_upd", {3'b000, upd}, 4'h0);
    checkValue("rst_err", {3'b000, err}, 4'h0);
    @(negedge clk);
    an_n  = 3'b111;
    seg_n = 7'b1111111;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput(4'd0, 4'd0, 4'd0, 1'b0);

    // Single digit: d1 = 2, one upd, not yet valid.
    applyStimulus(3'b110, 7'b0010010, 6, 1'b1, 4'd2, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(3'b111, 7'b1111111, 3, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Full scan 1,2,3 then repeat (no upd) then d2 -> 9.
    applyStimulus(3'b110, 7'b1001111, 6, 1'b1, 4'd1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(3'b101, 7'b0010010, 6, 1'b1, 4'd1, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus(3'b011, 7'b0000110, 6, 1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b1, 1'b0);
    applyStimulus(3'b110, 7'b1001111, 6, 1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'b101, 7'b0010010, 6, 1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'b011, 7'b0000110, 6, 1'b1, 4'd1, 4'd2, 4'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(3'b101, 7'b0000100, 6, 1'b1, 4'd1, 4'd9, 4'd3, 1'b1, 1'b1, 1'b0);

    // Glitch: 3-cycle hold is one short; two anodes active never captures.
    applyStimulus(3'b110, 7'b0000000, 3, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b100, 7'b1001111, 10, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(4'd1, 4'd9, 4'd3, 1'b1);

    // Invalid pattern raises err once; blank is ignored.
    applyStimulus(3'b110, 7'b1110000, 5, 1'b1, 4'd1, 4'd9, 4'd3, 1'b1, 1'b0, 1'b1);
    applyStimulus(3'b110, 7'b1111111, 6, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    checkOutput(4'd1, 4'd9, 4'd3, 1'b1);

    // Clear on the capture edge of d1 = 5 wins over the capture.
    applyStimulus(3'b110, 7'b0100100, LAT, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    an_n  = 3'b111;
    seg_n = 7'b1111111;
    repeat (8) @(negedge clk);
    checkOutput(4'd0, 4'd0, 4'd0, 1'b0);

    // Reset in the middle of tracking d2 = 7; the partial count is lost.
    an_n  = 3'b101;
    seg_n = 7'b0001111;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #2;
    checkOutput(4'd0, 4'd0, 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    an_n  = 3'b111;
    seg_n = 7'b1111111;
    repeat (10) @(negedge clk);
    checkOutput(4'd0, 4'd0, 4'd0, 1'b0);

    checkValue("sb_drained", 4'(sb.size()), 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
